sd_host_ctrl: RTL and testbench
===============================

SD_HOST_CTRL -- requirements
Module: sd_host_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 24'd10_000_000; cycles allowed in WAIT_DONE before timeout.
REQ-002 Parameter START_WINDOW, default 16; cycles allowed in WAIT_START for SD_IF_BUSY to rise.
REQ-003 CLK  in  1  system clock, 100MHz.
REQ-004 RESET  in  1  reset; synchronous, active-high.
REQ-005 HOST_WR  in  1  one-cycle host register write strobe.
REQ-006 HOST_RD  in  1  one-cycle host register read strobe.
REQ-007 HOST_ADDR  in  3  register index.
REQ-008 HOST_WDATA  in  8  write data.
REQ-009 HOST_RDATA  out  8  registered read data.
REQ-010 HOST_RVALID  out  1  HIGH one cycle after HOST_RD.
REQ-011 SD_ENABLE  out  1  request pulse to the SD interface.
REQ-012 SD_MODE  out  2  1=READ, 2=WRITE.
REQ-013 SD_SECTOR  out  32  sector number latched at issue.
REQ-014 SD_IF_BUSY  in  1  SD interface busy.
REQ-015 SD_STATUS_IN  in  8  SD interface status byte.
REQ-016 IRQ  out  1  completion interrupt, level.

Function
REQ-017 Register map: 0-3 sector bytes LSB..MSB (R/W); 4 write=command, read=STAT; 5 read=SD_STATUS_IN; 6 IRQ control (bit0 enable, write bit7=1 acks); 7 reads 8'h5D (ID).
REQ-018 STAT layout: {busy, done, err_start, err_timeout, err_rej, 1'b0, mode[1:0]}.
REQ-019 Command 8'h01 issues READ and 8'h02 issues WRITE; 8'h80 clears done/err bits and IRQ; all other values are ignored.
REQ-020 FSM states: IDLE, ISSUE, WAIT_START, WAIT_DONE, DONE.
REQ-021 IDLE/DONE + valid READ/WRITE command -> ISSUE: latch sector registers into SD_SECTOR, set SD_MODE, clear done/err bits.
REQ-022 ISSUE: SD_ENABLE HIGH exactly one cycle, then -> WAIT_START.
REQ-023 WAIT_START: SD_IF_BUSY HIGH -> WAIT_DONE; START_WINDOW cycles with no busy -> DONE with err_start=1.
REQ-024 WAIT_DONE: SD_IF_BUSY LOW -> DONE with done=1; timeout -> DONE with err_timeout=1.
REQ-025 A READ/WRITE command in ISSUE/WAIT_START/WAIT_DONE is ignored and sets err_rej=1; the in-flight operation continues unaffected.
REQ-026 Writes to sector registers are always accepted; SD_SECTOR changes only at issue.
REQ-027 busy=1 whenever state is ISSUE, WAIT_START or WAIT_DONE.
REQ-028 IRQ = irq_pend AND enable; irq_pend set on entry to DONE, cleared by ack or 8'h80.
REQ-029 Entry to DONE takes priority over an ack written in the same cycle; irq_pend stays set.
REQ-030 Read latency is one cycle; a read in the same cycle as a write to the same register returns the pre-write value.
REQ-031 The timeout counter is 24 bits, cleared on entry to WAIT_DONE, and does not wrap.

Reset
REQ-032 On RESET: state IDLE; SD_ENABLE=0, SD_MODE=0, SD_SECTOR=0, sector registers=0, STAT bits=0, irq_pend=0, enable=0, IRQ=0, HOST_RDATA=0, HOST_RVALID=0.
REQ-033 RESET mid-operation returns the block to IDLE immediately; no SD_ENABLE pulse is emitted.

Configuration
REQ-034 With macro SD_HOST_TIMEOUT_EN defined, the WAIT_DONE timeout of REQ-024 is built.
REQ-035 Without SD_HOST_TIMEOUT_EN, the counter is not instantiated, WAIT_DONE waits indefinitely, and err_timeout reads 0.

Structure
REQ-036 Package sd_host_pkg holds the state enum, the register index constants, the command codes (8'h01, 8'h02, 8'h80), the ID value and the STAT bit positions.
REQ-037 The FSM and timers live in sub-module sd_host_fsm; the top level holds the register file and read mux.

Verification
REQ-038 Write sector 0x00001234 to regs 0-3, write 8'h01 to reg 4, model busy for 100 cycles -> one SD_ENABLE pulse, SD_MODE=1, SD_SECTOR=0x00001234, STAT=8'h81 while busy, then 8'h41.
REQ-039 Issue 8'h02 with busy never asserted -> DONE after 16 cycles, STAT=8'h22; IRQ rises only if reg6 bit0=1.
REQ-040 Issue 8'h01 during WAIT_DONE -> no second pulse, err_rej=1; original op completes with done=1.
REQ-041 With SD_HOST_TIMEOUT_EN and TIMEOUT_CYCLES=50, hold busy high -> DONE with err_timeout=1 at cycle 50; without the macro the block stays in WAIT_DONE.
REQ-042 Assert RESET in WAIT_DONE -> all outputs at reset values the next cycle; reg7 reads 8'h5D.
REQ-043 Write ack in the same cycle as DONE entry -> IRQ remains HIGH; a second ack clears it.

Source files
------------

// File: rtl/sd_host_pkg.sv
// sd_host_pkg -- shared types and constants for the SD host controller.
// Holds the FSM state enum, the host register indices, the command codes,
// the ID value, the STAT bit positions and a STAT packing helper.
// Optional feature macro: SD_HOST_TIMEOUT_EN (used by sd_host_fsm).
package sd_host_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_START,
    ST_WAIT_DONE,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    MODE_NONE  = 2'd0,
    MODE_READ  = 2'd1,
    MODE_WRITE = 2'd2
  } sd_mode_e;

  localparam logic [2:0] REG_SEC0   = 3'd0;
  localparam logic [2:0] REG_SEC1   = 3'd1;
  localparam logic [2:0] REG_SEC2   = 3'd2;
  localparam logic [2:0] REG_SEC3   = 3'd3;
  localparam logic [2:0] REG_CMD    = 3'd4;  // write: command, read: STAT
  localparam logic [2:0] REG_SDSTAT = 3'd5;
  localparam logic [2:0] REG_IRQ    = 3'd6;
  localparam logic [2:0] REG_ID     = 3'd7;

  localparam logic [7:0] CMD_READ  = 8'h01;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_CLEAR = 8'h80;
  localparam logic [7:0] ID_VALUE  = 8'h5D;

  localparam int STAT_BUSY        = 7;
  localparam int STAT_DONE        = 6;
  localparam int STAT_ERR_START   = 5;
  localparam int STAT_ERR_TIMEOUT = 4;
  localparam int STAT_ERR_REJ     = 3;

  function automatic logic [7:0] pack_stat(input logic busy, input logic done,
                                           input logic err_start, input logic err_timeout,
                                           input logic err_rej, input logic [1:0] mode);
    logic [7:0] s;
    s = {6'b0, mode};
    s[STAT_BUSY]        = busy;
    s[STAT_DONE]        = done;
    s[STAT_ERR_START]   = err_start;
    s[STAT_ERR_TIMEOUT] = err_timeout;
    s[STAT_ERR_REJ]     = err_rej;
    return s;
  endfunction

endpackage

// File: rtl/sd_host_if.sv
// sd_host_if -- host register bus of the SD host controller.
// Signals: HOST_WR/HOST_RD one-cycle strobes, HOST_ADDR register index,
// HOST_WDATA write data, HOST_RDATA registered read data, HOST_RVALID
// read-data strobe. master = host side, slave = controller side.
interface sd_host_if;
  logic       HOST_WR;
  logic       HOST_RD;
  logic [2:0] HOST_ADDR;
  logic [7:0] HOST_WDATA;
  logic [7:0] HOST_RDATA;
  logic       HOST_RVALID;

  modport master (output HOST_WR, HOST_RD, HOST_ADDR, HOST_WDATA,
                  input  HOST_RDATA, HOST_RVALID);
  modport slave  (input  HOST_WR, HOST_RD, HOST_ADDR, HOST_WDATA,
                  output HOST_RDATA, HOST_RVALID);
endinterface

// File: rtl/sd_host_fsm.sv
// sd_host_fsm -- command sequencer and timers of the SD host controller.
// Ports: CLK, RESET (sync, active-high); decoded host commands (read, write,
// clear, irq ack); sector_i from the register file; sd_if_busy_i from the
// SD interface; SD request outputs (enable pulse, mode, sector); stat_o
// (STAT byte) and irq_pend_o.
// Optional feature: SD_HOST_TIMEOUT_EN builds the WAIT_DONE timeout counter.
//
// state         | meaning
// --------------+---------------------------------------------------------
// ST_IDLE       | no operation since reset
// ST_ISSUE      | SD_ENABLE high for this single cycle
// ST_WAIT_START | waiting up to START_WINDOW cycles for SD busy to rise
// ST_WAIT_DONE  | waiting for SD busy to fall (optionally with timeout)
// ST_DONE       | operation finished, result in STAT; accepts new command
module sd_host_fsm
  import sd_host_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000,
  parameter int unsigned START_WINDOW   = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        cmd_read_i,
  input  logic        cmd_write_i,
  input  logic        cmd_clear_i,
  input  logic        irq_ack_i,
  input  logic [31:0] sector_i,
  input  logic        sd_if_busy_i,
  output logic        sd_enable_o,
  output logic [1:0]  sd_mode_o,
  output logic [31:0] sd_sector_o,
  output logic [7:0]  stat_o,
  output logic        irq_pend_o
);

  if (TIMEOUT_CYCLES == 24'd0 || START_WINDOW == 0 || START_WINDOW > 65536) begin : g_param_chk
    $error("sd_host_fsm: TIMEOUT_CYCLES and START_WINDOW must be nonzero");
  end

  state_e      state_q;
  logic        sd_enable_q;
  logic [1:0]  mode_q;
  logic [31:0] sector_q;
  logic        done_q, err_start_q, err_to_q, err_rej_q, irq_pend_q;
  logic [15:0] start_cnt_q;
`ifdef SD_HOST_TIMEOUT_EN
  logic [23:0] to_cnt_q;
`endif

  logic issue, busy;
  assign issue = cmd_read_i | cmd_write_i;
  assign busy  = (state_q == ST_ISSUE) || (state_q == ST_WAIT_START) ||
                 (state_q == ST_WAIT_DONE);

  // Order matters: the clear/ack at the top is overridden by a DONE entry
  // in the case below, so a completion never loses its pending interrupt.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      sd_enable_q <= 1'b0;
      mode_q      <= MODE_NONE;
      sector_q    <= '0;
      done_q      <= 1'b0;
      err_start_q <= 1'b0;
      err_to_q    <= 1'b0;
      err_rej_q   <= 1'b0;
      irq_pend_q  <= 1'b0;
      start_cnt_q <= '0;
`ifdef SD_HOST_TIMEOUT_EN
      to_cnt_q    <= '0;
`endif
    end else begin
      sd_enable_q <= 1'b0;
      if (cmd_clear_i) begin
        done_q      <= 1'b0;
        err_start_q <= 1'b0;
        err_to_q    <= 1'b0;
        err_rej_q   <= 1'b0;
        irq_pend_q  <= 1'b0;
      end
      if (irq_ack_i) irq_pend_q <= 1'b0;

      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (issue) begin
            state_q     <= ST_ISSUE;
            sd_enable_q <= 1'b1;
            mode_q      <= cmd_read_i ? MODE_READ : MODE_WRITE;
            sector_q    <= sector_i;
            done_q      <= 1'b0;
            err_start_q <= 1'b0;
            err_to_q    <= 1'b0;
            err_rej_q   <= 1'b0;
          end
        end
        ST_ISSUE: begin
          state_q     <= ST_WAIT_START;
          start_cnt_q <= 16'(START_WINDOW - 1);
          if (issue) err_rej_q <= 1'b1;
        end
        ST_WAIT_START: begin
          if (sd_if_busy_i) begin
            state_q <= ST_WAIT_DONE;
`ifdef SD_HOST_TIMEOUT_EN
            to_cnt_q <= '0;
`endif
          end else if (start_cnt_q == 16'd0) begin
            state_q     <= ST_DONE;
            err_start_q <= 1'b1;
            irq_pend_q  <= 1'b1;
          end else begin
            start_cnt_q <= start_cnt_q - 16'd1;
          end
          if (issue) err_rej_q <= 1'b1;
        end
        ST_WAIT_DONE: begin
          if (!sd_if_busy_i) begin
            state_q    <= ST_DONE;
            done_q     <= 1'b1;
            irq_pend_q <= 1'b1;
          end
`ifdef SD_HOST_TIMEOUT_EN
          else if (to_cnt_q == TIMEOUT_CYCLES - 24'd1) begin
            state_q    <= ST_DONE;
            err_to_q   <= 1'b1;
            irq_pend_q <= 1'b1;
          end else if (to_cnt_q != 24'hFF_FFFF) begin
            to_cnt_q <= to_cnt_q + 24'd1;
          end
`endif
          if (issue) err_rej_q <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign sd_enable_o = sd_enable_q;
  assign sd_mode_o   = mode_q;
  assign sd_sector_o = sector_q;
  assign irq_pend_o  = irq_pend_q;
  assign stat_o      = pack_stat(busy, done_q, err_start_q, err_to_q, err_rej_q, mode_q);

endmodule

// File: rtl/sd_host_ctrl.sv
// sd_host_ctrl -- SD host controller top: host register file, read mux and
// command decode; sequencing is in sd_host_fsm.
// Ports: CLK, RESET (sync, active-high); host (sd_host_if.slave register
// bus); SD_ENABLE/SD_MODE/SD_SECTOR request to the SD interface;
// SD_IF_BUSY/SD_STATUS_IN from it; IRQ level completion interrupt.
// Optional feature: SD_HOST_TIMEOUT_EN enables the WAIT_DONE timeout.
module sd_host_ctrl
  import sd_host_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000,
  parameter int unsigned START_WINDOW   = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  sd_host_if.slave    host,
  output logic        SD_ENABLE,
  output logic [1:0]  SD_MODE,
  output logic [31:0] SD_SECTOR,
  input  logic        SD_IF_BUSY,
  input  logic [7:0]  SD_STATUS_IN,
  output logic        IRQ
);

  logic [31:0] sector_q;
  logic        irq_en_q;
  logic [7:0]  rdata_q, rdata_d;
  logic        rvalid_q;
  logic        cmd_we, cmd_read, cmd_write, cmd_clear, irq_ack, irq_pend;
  logic [7:0]  stat;

  assign cmd_we    = host.HOST_WR && (host.HOST_ADDR == REG_CMD);
  assign cmd_read  = cmd_we && (host.HOST_WDATA == CMD_READ);
  assign cmd_write = cmd_we && (host.HOST_WDATA == CMD_WRITE);
  assign cmd_clear = cmd_we && (host.HOST_WDATA == CMD_CLEAR);
  assign irq_ack   = host.HOST_WR && (host.HOST_ADDR == REG_IRQ) && host.HOST_WDATA[7];

  sd_host_fsm #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .START_WINDOW   (START_WINDOW)
  ) u_fsm (
    .CLK          (CLK),
    .RESET        (RESET),
    .cmd_read_i   (cmd_read),
    .cmd_write_i  (cmd_write),
    .cmd_clear_i  (cmd_clear),
    .irq_ack_i    (irq_ack),
    .sector_i     (sector_q),
    .sd_if_busy_i (SD_IF_BUSY),
    .sd_enable_o  (SD_ENABLE),
    .sd_mode_o    (SD_MODE),
    .sd_sector_o  (SD_SECTOR),
    .stat_o       (stat),
    .irq_pend_o   (irq_pend)
  );

  // Mux reads the current (pre-write) register values, so a read and write
  // to the same register in one cycle returns the old contents.
  always_comb begin
    rdata_d = '0;
    case (host.HOST_ADDR)
      REG_SEC0:   rdata_d = sector_q[7:0];
      REG_SEC1:   rdata_d = sector_q[15:8];
      REG_SEC2:   rdata_d = sector_q[23:16];
      REG_SEC3:   rdata_d = sector_q[31:24];
      REG_CMD:    rdata_d = stat;
      REG_SDSTAT: rdata_d = SD_STATUS_IN;
      REG_IRQ:    rdata_d = {7'b0, irq_en_q};
      REG_ID:     rdata_d = ID_VALUE;
      default:    rdata_d = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sector_q <= '0;
      irq_en_q <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      if (host.HOST_WR) begin
        case (host.HOST_ADDR)
          REG_SEC0: sector_q[7:0]   <= host.HOST_WDATA;
          REG_SEC1: sector_q[15:8]  <= host.HOST_WDATA;
          REG_SEC2: sector_q[23:16] <= host.HOST_WDATA;
          REG_SEC3: sector_q[31:24] <= host.HOST_WDATA;
          REG_IRQ:  irq_en_q        <= host.HOST_WDATA[0];
          default:  ;
        endcase
      end
      rvalid_q <= host.HOST_RD;
      if (host.HOST_RD) rdata_q <= rdata_d;
    end
  end

  assign host.HOST_RDATA  = rdata_q;
  assign host.HOST_RVALID = rvalid_q;
  assign IRQ              = irq_pend & irq_en_q;

endmodule

// File: tb/tb_sd_host_ctrl.sv
// tb_sd_host_ctrl -- scoreboard bench for sd_host_ctrl.
// Read expectations and SD request expectations are queued when stimulus is
// driven and checked by a monitor when HOST_RVALID / SD_ENABLE appear.
// Honors SD_HOST_TIMEOUT_EN for the timeout scenario.
module tb_sd_host_ctrl;
  import sd_host_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        SD_ENABLE;
  logic [1:0]  SD_MODE;
  logic [31:0] SD_SECTOR;
  logic        SD_IF_BUSY = 1'b0;
  logic [7:0]  SD_STATUS_IN = 8'hA5;
  logic        IRQ;

  sd_host_if bus ();

  sd_host_ctrl #(
    .TIMEOUT_CYCLES (24'd50),
    .START_WINDOW   (16)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .host         (bus),
    .SD_ENABLE    (SD_ENABLE),
    .SD_MODE      (SD_MODE),
    .SD_SECTOR    (SD_SECTOR),
    .SD_IF_BUSY   (SD_IF_BUSY),
    .SD_STATUS_IN (SD_STATUS_IN),
    .IRQ          (IRQ)
  );

  always #5 CLK = ~CLK;

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_pulse = 0;
  int          exp_pulses = 0;
  logic [7:0]  exp_rd_q[$];
  string       rd_tag_q[$];
  logic [33:0] exp_iss_q[$];   // {mode, sector}
  logic [31:0] sec_model = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (bus.HOST_RVALID === 1'b1) begin
      if (exp_rd_q.size() == 0) chk("rd_unexpected", 1, 0);
      else chk(rd_tag_q.pop_front(), {24'b0, bus.HOST_RDATA}, {24'b0, exp_rd_q.pop_front()});
    end
    if (SD_ENABLE === 1'b1) begin
      logic [33:0] e;
      n_pulse++;
      if (exp_iss_q.size() == 0) chk("enable_unexpected", 1, 0);
      else begin
        e = exp_iss_q.pop_front();
        chk("sd_mode", {30'b0, SD_MODE}, {30'b0, e[33:32]});
        chk("sd_sector", SD_SECTOR, e[31:0]);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic host_write(input logic [2:0] a, input logic [7:0] d);
    bus.HOST_WR = 1'b1; bus.HOST_ADDR = a; bus.HOST_WDATA = d;
    @(posedge CLK); #1;
    bus.HOST_WR = 1'b0;
  endtask

  task automatic host_read(input string tag, input logic [2:0] a, input logic [7:0] exp);
    exp_rd_q.push_back(exp); rd_tag_q.push_back(tag);
    bus.HOST_RD = 1'b1; bus.HOST_ADDR = a;
    @(posedge CLK); #1;
    bus.HOST_RD = 1'b0;
  endtask

  task automatic wr_sector(input logic [31:0] s);
    for (int i = 0; i < 4; i++) host_write(3'(i), s[8*i +: 8]);
    sec_model = s;
  endtask

  task automatic issue(input logic [7:0] cmd);
    exp_iss_q.push_back({(cmd == CMD_READ) ? 2'd1 : 2'd2, sec_model});
    exp_pulses++;
    host_write(REG_CMD, cmd);
  endtask

  // Cycles after the current point until IRQ is first seen high, or -1.
  task automatic irq_rise(input int limit, output int rise);
    rise = -1;
    for (int i = 1; i <= limit; i++) begin
      @(posedge CLK); #1;
      if (IRQ === 1'b1 && rise < 0) rise = i;
    end
  endtask

  initial begin
    int rise;
    bus.HOST_WR = 1'b0; bus.HOST_RD = 1'b0; bus.HOST_ADDR = '0; bus.HOST_WDATA = '0;

    // reset values
    tick(3);
    chk("rst_enable", {31'b0, SD_ENABLE}, 0);
    chk("rst_mode", {30'b0, SD_MODE}, 0);
    chk("rst_sector", SD_SECTOR, 0);
    chk("rst_irq", {31'b0, IRQ}, 0);
    chk("rst_rvalid", {31'b0, bus.HOST_RVALID}, 0);
    RESET = 1'b0;
    tick(1);
    host_read("rst_stat", REG_CMD, 8'h00);
    host_read("rst_sdstat", REG_SDSTAT, 8'hA5);
    host_read("rst_id", REG_ID, 8'h5D);
    host_read("rst_irqreg", REG_IRQ, 8'h00);

    // read with busy modelled for 100 cycles
    wr_sector(32'h0000_1234);
    host_read("sec0_rb", REG_SEC0, 8'h34);
    host_read("sec1_rb", REG_SEC1, 8'h12);
    issue(CMD_READ);
    SD_IF_BUSY = 1'b1;
    tick(49);
    host_read("stat_busy", REG_CMD, 8'h81);
    tick(50);
    SD_IF_BUSY = 1'b0;
    tick(2);
    host_read("stat_done", REG_CMD, 8'h41);
    chk("irq_masked", {31'b0, IRQ}, 0);
    host_write(REG_IRQ, 8'h01);
    chk("irq_enabled", {31'b0, IRQ}, 1);
    host_write(REG_IRQ, 8'h81);
    chk("irq_acked", {31'b0, IRQ}, 0);

    // start window expiry, IRQ enabled
    wr_sector(32'hDEAD_BEEF);
    chk("sector_hold", SD_SECTOR, 32'h0000_1234);
    issue(CMD_WRITE);
    irq_rise(40, rise);
    chk("start_window", rise, 17);
    host_read("stat_errstart", REG_CMD, 8'h22);
    host_write(REG_CMD, CMD_CLEAR);
    chk("irq_clear_cmd", {31'b0, IRQ}, 0);
    host_read("stat_cleared", REG_CMD, 8'h02);

    // start window expiry, IRQ disabled
    host_write(REG_IRQ, 8'h00);
    issue(CMD_WRITE);
    irq_rise(40, rise);
    chk("irq_off_window", rise, -1);
    host_read("stat_errstart2", REG_CMD, 8'h22);
    host_write(REG_IRQ, 8'h01);
    chk("irq_pend_kept", {31'b0, IRQ}, 1);
    host_write(REG_CMD, CMD_CLEAR);
    host_write(REG_CMD, 8'h55);
    tick(3);
    host_read("stat_badcmd", REG_CMD, 8'h02);
    SD_STATUS_IN = 8'h3C;
    host_read("sdstat2", REG_SDSTAT, 8'h3C);

    // rejected command during WAIT_DONE; ack on the DONE entry cycle
    issue(CMD_READ);
    SD_IF_BUSY = 1'b1;
    tick(5);
    host_write(REG_CMD, CMD_READ);
    host_read("stat_rej", REG_CMD, 8'h89);
    SD_IF_BUSY = 1'b0;
    host_write(REG_IRQ, 8'h81);
    chk("irq_ack_race", {31'b0, IRQ}, 1);
    host_read("stat_rej_done", REG_CMD, 8'h49);
    host_write(REG_IRQ, 8'h81);
    chk("irq_second_ack", {31'b0, IRQ}, 0);
    host_write(REG_CMD, CMD_CLEAR);

    // WAIT_DONE timeout
    issue(CMD_WRITE);
    SD_IF_BUSY = 1'b1;
    irq_rise(200, rise);
`ifdef SD_HOST_TIMEOUT_EN
    chk("timeout_cycle", rise, 52);
    host_read("stat_timeout", REG_CMD, 8'h12);
    issue(CMD_READ);
    tick(5);
`else
    chk("no_timeout", rise, -1);
    host_read("stat_waiting", REG_CMD, 8'h82);
`endif

    // reset in WAIT_DONE
    RESET = 1'b1;
    tick(1);
    chk("mid_rst_enable", {31'b0, SD_ENABLE}, 0);
    chk("mid_rst_mode", {30'b0, SD_MODE}, 0);
    chk("mid_rst_sector", SD_SECTOR, 0);
    chk("mid_rst_irq", {31'b0, IRQ}, 0);
    chk("mid_rst_rdata", {24'b0, bus.HOST_RDATA}, 0);
    chk("mid_rst_rvalid", {31'b0, bus.HOST_RVALID}, 0);
    RESET = 1'b0;
    SD_IF_BUSY = 1'b0;
    sec_model = '0;
    tick(2);
    host_read("post_rst_id", REG_ID, 8'h5D);
    host_read("post_rst_stat", REG_CMD, 8'h00);
    host_read("post_rst_sec3", REG_SEC3, 8'h00);

    // read and write to the same register in one cycle
    exp_rd_q.push_back(8'h00); rd_tag_q.push_back("rd_wr_same");
    bus.HOST_WR = 1'b1; bus.HOST_RD = 1'b1; bus.HOST_ADDR = REG_SEC1; bus.HOST_WDATA = 8'h77;
    @(posedge CLK); #1;
    bus.HOST_WR = 1'b0; bus.HOST_RD = 1'b0;
    host_read("rd_after_wr", REG_SEC1, 8'h77);
    tick(3);

    chk("pulse_count", n_pulse, exp_pulses);
    chk("rd_q_drained", exp_rd_q.size(), 0);
    chk("iss_q_drained", exp_iss_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
